// File: rtl/cacheline_adapter_pkg.sv
// Shared constants and state encoding for the cache-line to memory-burst adapter.
package cacheline_adapter_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_REQ   = 3'd1;
    localparam state_t ST_RD_WAIT  = 3'd2;
    localparam state_t ST_WR_BURST = 3'd3;
    localparam state_t ST_RESP     = 3'd4;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit cache line read/write on dfp_* into a 4-beat 64-bit burst on bmem_*.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    state_t                  state;
    logic [1:0]              count;
    logic [31:0]             addr_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [LINE_WIDTH-1:0]   rdata_q;
    logic [7:0]              slot_lsb;

    assign slot_lsb = {count, 6'd0};

    // rdata_q is only refreshed when a read completes, so writes never disturb dfp_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= 2'd0;
            addr_q  <= 32'd0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dfp_write) begin
                        addr_q <= dfp_addr & LINE_MASK;
                        line_q <= dfp_wdata;
                        count  <= 2'd0;
                        state  <= ST_WR_BURST;
                    end else if (dfp_read) begin
                        addr_q <= dfp_addr & LINE_MASK;
                        count  <= 2'd0;
                        state  <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (bmem_ready) begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                        line_q[slot_lsb +: BEAT_WIDTH] <= bmem_rdata;
                        count <= count + 2'd1;
                        if (count == 2'd3) begin
                            rdata_q <= {bmem_rdata, line_q[LINE_WIDTH-BEAT_WIDTH-1:0]};
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_WR_BURST: begin
                    if (bmem_ready) begin
                        count <= count + 2'd1;
                        if (count == 2'd3) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bmem_addr  = addr_q;
    assign bmem_read  = (state == ST_RD_REQ);
    assign bmem_write = (state == ST_WR_BURST);
    assign bmem_wdata = bmem_write ? line_q[slot_lsb +: BEAT_WIDTH] : '0;
    assign dfp_resp   = (state == ST_RESP);
    assign dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reset, reads, writes, stalls, stray beats and aborts.
module tb_cacheline_adapter;
    import cacheline_adapter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hB3B3_0000_1111_B3B3, 64'hB2B2_0000_2222_B2B2,
                                       64'hB1B1_0000_3333_B1B1, 64'hB0B0_0000_4444_B0B0};
    localparam logic [255:0] LINE_W = 256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_FEDCBA9889ABCDEF;
    localparam logic [255:0] LINE_V = 256'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0_CAFEBABE_DEADBEEF;
    localparam logic [255:0] LINE_C = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                       64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    localparam logic [255:0] LINE_D = {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                                       64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000};

    cacheline_adapter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    // Upstream must never raise read and write together
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dfp_read && dfp_write))
                else $error("[TB] FAIL proto_rw_overlap read=%0b write=%0b", dfp_read, dfp_write);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_resp"},   dfp_resp,   0);
        checkOutput({tag, "_rdata"},  dfp_rdata,  0);
        checkOutput({tag, "_bread"},  bmem_read,  0);
        checkOutput({tag, "_bwrite"}, bmem_write, 0);
        checkOutput({tag, "_baddr"},  bmem_addr,  0);
        checkOutput({tag, "_bwdata"}, bmem_wdata, 0);
    endtask

    task automatic applyRead(input logic [31:0] a, input logic [255:0] line, input logic [255:0] prev,
                             input int ready_low, input int gap, input bit stray);
        int held;
        dfp_addr   = a;
        dfp_read   = 1'b1;
        bmem_ready = (ready_low == 0);
        tick();
        checkOutput("rd_req",        bmem_read, 1);
        checkOutput("rd_addr",       bmem_addr, a & LINE_MASK);
        checkOutput("rd_prev_rdata", dfp_rdata, prev);
        held = 1;
        for (int i = 0; i < ready_low; i++) begin
            tick();
            if (bmem_read) held++;
        end
        bmem_ready = 1'b1;
        tick();
        checkOutput("rd_req_cycles", held, ready_low + 1);
        checkOutput("rd_req_drop",   bmem_read, 0);
        repeat (gap) tick();
        for (int b = 0; b < 4; b++) begin
            if (stray && b == 2) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'h2000_0000;
                bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
                tick();
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = a & LINE_MASK;
            bmem_rdata  = line[64*b +: 64];
            checkOutput("rd_no_early_resp", dfp_resp, 0);
            checkOutput("rd_rdata_stable",  dfp_rdata, prev);
            tick();
        end
        bmem_rvalid = 1'b0;
        checkOutput("rd_resp", dfp_resp, 1);
        checkOutput("rd_line", dfp_rdata, line);
        dfp_read = 1'b0;
        tick();
        checkOutput("rd_resp_pulse", dfp_resp, 0);
        checkOutput("rd_line_held",  dfp_rdata, line);
    endtask

    task automatic applyWrite(input logic [31:0] a, input logic [255:0] line, input logic [255:0] prev,
                              input bit toggle);
        int cyc;
        int k;
        int stalls;
        bit got_resp;
        dfp_addr   = a;
        dfp_write  = 1'b1;
        dfp_wdata  = line;
        bmem_ready = 1'b1;
        tick();
        cyc = 1;
        k = 0;
        stalls = 0;
        got_resp = 1'b0;
        while (!got_resp && cyc < 40) begin
            if (dfp_resp) begin
                got_resp = 1'b1;
            end else begin
                checkOutput("wr_valid", bmem_write, 1);
                checkOutput("wr_addr",  bmem_addr, a & LINE_MASK);
                checkOutput("wr_beat",  bmem_wdata, line[64*(k%4) +: 64]);
                bmem_ready = toggle ? (cyc % 2 == 0) : 1'b1;
                if (bmem_ready) k++;
                else stalls++;
                tick();
                cyc++;
            end
        end
        checkOutput("wr_resp_seen",  got_resp, 1);
        checkOutput("wr_resp_cycle", cyc, 5 + stalls);
        checkOutput("wr_beats",      k, 4);
        checkOutput("wr_rdata_kept", dfp_rdata, prev);
        dfp_write  = 1'b0;
        bmem_ready = 1'b1;
        tick();
        checkOutput("wr_resp_pulse", dfp_resp, 0);
        checkOutput("wr_write_drop", bmem_write, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        dfp_addr    = 32'd0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = 32'd0;
        bmem_rdata  = 64'd0;
        bmem_rvalid = 1'b0;

        repeat (3) tick();
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-cycle during a write burst clears outputs immediately
        dfp_addr   = 32'h3000_0044;
        dfp_write  = 1'b1;
        dfp_wdata  = LINE_W;
        bmem_ready = 1'b0;
        tick();
        checkOutput("pre_reset_write", bmem_write, 1);
        #2 rst_n = 1'b0;
        dfp_write = 1'b0;
        #1 checkIdleOutputs("async_reset");
        #2 rst_n = 1'b1;
        tick();

        applyRead(32'h1000_0024, LINE_A, '0, 0, 2, 1'b0);
        applyRead(32'h1000_0100, LINE_B, LINE_A, 2, 0, 1'b1);
        applyWrite(32'h5000_001F, LINE_W, LINE_B, 1'b0);
        applyWrite(32'h5000_0040, LINE_V, LINE_B, 1'b1);
        applyRead(32'h5000_0040, LINE_C, LINE_B, 0, 1, 1'b0);

        // Abort a read after two beats, then let the late beats arrive in IDLE
        dfp_addr    = 32'h4000_0000;
        dfp_read    = 1'b1;
        bmem_ready  = 1'b1;
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0000;
            bmem_rdata  = LINE_D[64*b +: 64];
            tick();
        end
        #2 rst_n = 1'b0;
        dfp_read = 1'b0;
        #1 checkIdleOutputs("abort_reset");
        #2 rst_n = 1'b1;
        for (int b = 2; b < 4; b++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0000;
            bmem_rdata  = LINE_D[64*b +: 64];
            tick();
            checkOutput("abort_no_resp", dfp_resp, 0);
            checkOutput("abort_idle",    bmem_read, 0);
        end
        bmem_rvalid = 1'b0;
        tick();
        checkOutput("abort_quiet", dfp_resp, 0);

        applyRead(32'h4000_0008, LINE_D, '0, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache `dfp_*` port: accepts one 256-bit line read or write from the instruction or data cache and converts it into a 4-beat, 64-bit burst on the banked memory (`bmem_*`) interface. For reads it collects the returned beats into a full line; for writes it streams the line out. It sits between each cache (or the arbiter in front of them) and main memory.

## Interface
Parameters:
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, memory beat width; BEATS = LINE_WIDTH/BEAT_WIDTH = 4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dfp_addr  in  32  line request address; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  line to write, stable while dfp_write held
- dfp_rdata  out  256  assembled read line, valid with dfp_resp
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, always {addr[31:5], 5'b0}
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts request/beat this cycle
- bmem_raddr  in  32  address tag of returning beat
- bmem_rdata  in  64  returning read beat
- bmem_rvalid  in  1  returning beat valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE: if dfp_write -> latch aligned address and dfp_wdata, beat count = 0, go WR_BURST; else if dfp_read -> latch aligned address, go RD_REQ. Simultaneous read+write is an upstream protocol violation; write wins, and the bench asserts that it never happens.
- RD_REQ: bmem_read = 1, bmem_addr = latched address; on bmem_ready -> RD_WAIT.
- RD_WAIT: each bmem_rvalid with bmem_raddr == latched address stores bmem_rdata into beat slot [count] (slot i = line bits [64i+63:64i]), count++. Beats with a mismatched raddr are dropped. On the 4th stored beat -> RESP.
- WR_BURST: bmem_write = 1, bmem_addr = latched address, bmem_wdata = latched line slot [count]. On bmem_ready, count++. After slot 3 is accepted -> RESP.
- RESP: dfp_resp = 1 for exactly one cycle -> IDLE. dfp_rdata holds its value until the next read completes. After a write, dfp_rdata still holds the last read line.
- bmem_rvalid is ignored in every state except RD_WAIT.
- The beat counter is 2 bits and wraps naturally. Terminal condition is count == 3 at the event.

## Timing
- Reset (async assert, sync release): state IDLE, count 0, latched address 0. All outputs 0, including dfp_rdata, dfp_resp, bmem_read, bmem_write, bmem_addr and bmem_wdata.
- Reset mid-burst aborts the transaction. Beats still returning afterwards are ignored in IDLE.
- All outputs decode from registered state and registers only. There is no combinational path from dfp_* inputs to bmem_* outputs.
- Read: dfp_read sampled at edge 0 -> bmem_read high in cycle 1. If memory returns beats in cycles k..k+3, dfp_resp is high in cycle k+4.
- Write with bmem_ready always high: dfp_write sampled at edge 0 -> beats in cycles 1–4 -> dfp_resp in cycle 5. Every cycle with bmem_ready low adds one cycle, and bmem_wdata is held.
- IDLE does not look at requests during RESP. A request still held in the cycle after RESP is treated as a new request, so upstream must drop the request on dfp_resp.

## Structure
- The shared types package holds: the state enum, LINE_WIDTH/BEAT_WIDTH/BEATS constants, and the line-alignment mask 32'hFFFF_FFE0.
- Single module, no sub-modules. It contains the FSM, a 2-bit counter, a 32-bit address register and a 256-bit line register, shared between read assembly and write data.

## Test plan
- Reset: hold rst_n low mid-cycle -> all outputs 0 immediately. Release, then dfp_read to 0x1000_0024 -> bmem_addr = 0x1000_0020 and bmem_read in the next cycle.
- Read, memory latency 3: beats 0x11…11, 0x22…22, 0x33…33, 0x44…44 -> one dfp_resp pulse, with dfp_rdata = {0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- Read with bmem_ready low for 2 cycles, plus a stray rvalid carrying raddr 0x2000_0000 -> bmem_read held 3 cycles, stray beat dropped, line correct.
- Write of 256'h0123…CDEF with ready always high -> 4 bmem_write cycles, beat 0 = line[63:0], dfp_resp in cycle 5. Then repeat with ready toggling: beats held, no duplicates.
- Reset asserted after 2 read beats, then the remaining 2 beats arrive -> no dfp_resp. A following read completes normally.
- Back-to-back write then read from the same cache -> the second request starts the cycle after RESP, and dfp_rdata is unchanged until the read's resp.
